// File: rtl/sim_defs.sv
// sim_defs: shared definitions for the traffic-injection slice.
//   - Simulator state encodings driven onto the 2-bit state bus.
//   - LFSR width/mask and packet field widths.
//   - Small helpers: Galois LFSR step and saturating increment.
package sim_defs;

    typedef enum logic [1:0] {
        SIM_INVALID     = 2'b00,
        SIM_INITIALIZED = 2'b01,
        SIM_RUNNING     = 2'b10,
        SIM_COMPLETED   = 2'b11
    } sim_state_e;

    localparam int unsigned LFSR_WIDTH  = 16;
    localparam int unsigned SEQ_WIDTH   = 16;
    localparam int unsigned COUNT_WIDTH = 32;

    // Galois form of taps 16,14,13,11.
    localparam logic [LFSR_WIDTH-1:0] LFSR_MASK = 16'hB400;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/packet_fifo.sv
// packet_fifo: registered-storage FIFO, no write-to-read bypass.
// Ports:
//   clk, reset        rising-edge clock, async active-high reset (empties FIFO)
//   push, push_data   write request; accepted when not full or when popping
//   pop               read request; ignored when empty
//   head_data         entry at the read pointer (zero after reset)
//   full, empty       occupancy flags
module packet_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/traffic_injector.sv
// traffic_injector: LFSR-driven synthetic packet source for one network node.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   state               simulator state (only RUNNING generates traffic)
//   current_cycle       simulator cycle, captured as packet timestamp
//   out_valid/out_ready downstream handshake on the FIFO head
//   out_src/out_dest    head packet source / destination node
//   out_timestamp       head packet generation cycle
//   out_seq             head packet sequence number
//   injected_count      saturating count of accepted packets
//   dropped_count       saturating count of packets lost to a full FIFO
//   done                COMPLETED and nothing left queued
module traffic_injector
    import sim_defs::*;
#(
    parameter int unsigned MAX_CYCLE_WIDTH = 32,
    parameter int unsigned NODE_ID_WIDTH   = 4,
    parameter int unsigned NODE_ID         = 0,
    parameter logic [7:0]  INJ_THRESHOLD   = 8'd32,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 state,
    input  logic [MAX_CYCLE_WIDTH-1:0] current_cycle,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NODE_ID_WIDTH-1:0]   out_src,
    output logic [NODE_ID_WIDTH-1:0]   out_dest,
    output logic [MAX_CYCLE_WIDTH-1:0] out_timestamp,
    output logic [SEQ_WIDTH-1:0]       out_seq,
    output logic [COUNT_WIDTH-1:0]     injected_count,
    output logic [COUNT_WIDTH-1:0]     dropped_count,
    output logic                       done
);

    localparam int unsigned PKT_W = 2 * NODE_ID_WIDTH + MAX_CYCLE_WIDTH + SEQ_WIDTH;
    localparam logic [NODE_ID_WIDTH-1:0] SELF_ID = NODE_ID_WIDTH'(NODE_ID);

    logic [LFSR_WIDTH-1:0]    lfsr_q;
    logic [SEQ_WIDTH-1:0]     seq_q;
    logic [COUNT_WIDTH-1:0]   injected_q;
    logic [COUNT_WIDTH-1:0]   dropped_q;

    logic                     running;
    logic                     gen;
    logic                     pop;
    logic                     accept;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [NODE_ID_WIDTH-1:0] dest_raw;
    logic [NODE_ID_WIDTH-1:0] dest;
    logic [PKT_W-1:0]         push_data;
    logic [PKT_W-1:0]         head_data;

    assign running  = (state == SIM_RUNNING);
    assign gen      = running && (lfsr_q[7:0] < INJ_THRESHOLD);
    assign dest_raw = lfsr_q[8 +: NODE_ID_WIDTH];
    // Never address ourselves; the increment wraps within the node-id width.
    assign dest     = (dest_raw == SELF_ID) ? SELF_ID + 1'b1 : dest_raw;

    assign pop       = out_valid && out_ready;
    assign accept    = gen && (!fifo_full || pop);
    assign push_data = {SELF_ID, dest, current_cycle, seq_q};

    packet_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (gen),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {out_src, out_dest, out_timestamp, out_seq} = head_data;
    assign out_valid      = !fifo_empty;
    assign done           = (state == SIM_COMPLETED) && fifo_empty;
    assign injected_count = injected_q;
    assign dropped_count  = dropped_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q     <= LFSR_SEED;
            seq_q      <= '0;
            injected_q <= '0;
            dropped_q  <= '0;
        end else begin
            if (running) begin
                lfsr_q <= lfsr_next(lfsr_q);
            end
            if (accept) begin
                seq_q      <= seq_q + 1'b1;
                injected_q <= sat_inc(injected_q);
            end else if (gen) begin
                dropped_q  <= sat_inc(dropped_q);
            end
        end
    end

endmodule

// File: tb/tb_traffic_injector.sv
// Directed bench for traffic_injector with a cycle-level reference model.
module tb_traffic_injector;

    localparam int unsigned CW = 32;
    localparam int unsigned NW = 4;
    localparam logic [NW-1:0] NODE_L = 4'd5;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] MASK = 16'hB400;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    state;
    logic [CW-1:0] current_cycle;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] out_src;
    logic [NW-1:0] out_dest;
    logic [CW-1:0] out_timestamp;
    logic [15:0]   out_seq;
    logic [31:0]   injected_count;
    logic [31:0]   dropped_count;
    logic          done;

    traffic_injector #(
        .MAX_CYCLE_WIDTH (CW),
        .NODE_ID_WIDTH   (NW),
        .NODE_ID         (5),
        .INJ_THRESHOLD   (8'd255),
        .LFSR_SEED       (SEED),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .state          (state),
        .current_cycle  (current_cycle),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_src        (out_src),
        .out_dest       (out_dest),
        .out_timestamp  (out_timestamp),
        .out_seq        (out_seq),
        .injected_count (injected_count),
        .dropped_count  (dropped_count),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NW-1:0] dest;
        logic [CW-1:0] ts;
        logic [15:0]   seq;
    } pkt_t;

    pkt_t        q[$];
    logic [15:0] lfsr_m;
    logic [15:0] seq_m;
    int unsigned inj_m;
    int unsigned drop_m;
    int unsigned gen_m;
    logic [CW-1:0] cyc = 32'd100;
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        lfsr_m = SEED;
        seq_m  = 16'd0;
        inj_m  = 0;
        drop_m = 0;
        gen_m  = 0;
    endtask

    task automatic compare_all(input logic [1:0] st);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("out_src", out_src, NODE_L);
            check("out_dest", out_dest, q[0].dest);
            check("dest_not_self", out_dest != NODE_L, 1'b1);
            check("out_timestamp", out_timestamp, q[0].ts);
            check("out_seq", out_seq, q[0].seq);
        end
        check("injected_count", injected_count, inj_m);
        check("dropped_count", dropped_count, drop_m);
        check("done", done, (st == 2'b11) && (q.size() == 0));
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare.
    task automatic step(input logic [1:0] st, input logic rdy);
        logic          running;
        logic          pop;
        logic          gen;
        logic [NW-1:0] d;
        pkt_t          p;
        state         = st;
        out_ready     = rdy;
        current_cycle = cyc;
        running = (st == 2'b10);
        pop     = (q.size() != 0) && rdy;
        gen     = running && (lfsr_m[7:0] < 8'd255);
        @(posedge clk);
        if (pop) p = q.pop_front();
        if (gen) begin
            gen_m++;
            if (q.size() < 4) begin
                d = lfsr_m[11:8];
                if (d == NODE_L) d = d + 1'b1;
                p.dest = d;
                p.ts   = cyc;
                p.seq  = seq_m;
                q.push_back(p);
                seq_m = seq_m + 1'b1;
                inj_m++;
            end else begin
                drop_m++;
            end
        end
        if (running) lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ MASK) : (lfsr_m >> 1);
        cyc = cyc + 1;
        #1;
        compare_all(st);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    logic [CW-1:0] ts_first;
    int unsigned   drop_before;
    int            tries;

    initial begin
        reset         = 1'b1;
        state         = 2'b00;
        out_ready     = 1'b0;
        current_cycle = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_injected", injected_count, 32'd0);
        check("rst_dropped", dropped_count, 32'd0);
        check("rst_done", done, 1'b0);
        check("rst_head", {out_src, out_dest, out_timestamp, out_seq}, 64'd0);
        check("rst_lfsr", dut.lfsr_q, SEED);
        reset = 1'b0;

        // Initialized: nothing generated, LFSR held.
        repeat (10) step(2'b01, 1'b1);
        check("init_out_valid", out_valid, 1'b0);
        check("init_injected", injected_count, 32'd0);
        check("init_lfsr", dut.lfsr_q, 16'hACE1);

        // Running with a ready sink: everything drains, nothing dropped.
        repeat (100) step(2'b10, 1'b1);
        check("run_dropped_zero", dropped_count, 32'd0);
        check("run_injected", injected_count, inj_m);

        // Running with a stalled sink: FIFO fills to 4, rest dropped.
        apply_reset();
        ts_first = cyc;
        repeat (50) step(2'b10, 1'b0);
        check("stall_injected", injected_count, 32'd4);
        check("stall_dropped", dropped_count, gen_m - 4);
        check("stall_head_seq", out_seq, 16'd0);
        check("stall_head_ts", out_timestamp, ts_first);
        check("stall_occupancy", dut.u_fifo.count_q, 3'd4);

        // Full FIFO, pop and generation in the same cycle.
        tries = 0;
        while (lfsr_m[7:0] == 8'hFF && tries < 10) begin
            step(2'b10, 1'b0);
            tries++;
        end
        drop_before = drop_m;
        step(2'b10, 1'b1);
        check("fullpop_dropped", dropped_count, drop_before);
        check("fullpop_injected", injected_count, 32'd5);
        check("fullpop_occupancy", dut.u_fifo.count_q, 3'd4);

        // Drain one without generating, then complete with 3 queued.
        step(2'b01, 1'b1);
        check("pre_done_occupancy", dut.u_fifo.count_q, 3'd3);
        repeat (2) step(2'b11, 1'b1);
        check("done_low_while_queued", done, 1'b0);
        step(2'b11, 1'b1);
        check("done_after_drain", done, 1'b1);
        check("done_no_valid", out_valid, 1'b0);
        check("done_injected", injected_count, 32'd5);
        step(2'b11, 1'b1);
        check("done_holds", done, 1'b1);

        // Asynchronous reset with two packets queued and the sink ready.
        apply_reset();
        repeat (2) step(2'b10, 1'b0);
        check("pre_reset_occupancy", dut.u_fifo.count_q, 3'd2);
        out_ready = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_injected", injected_count, 32'd0);
        check("async_dropped", dropped_count, 32'd0);
        check("async_head", {out_src, out_dest, out_timestamp, out_seq}, 64'd0);
        check("async_lfsr", dut.lfsr_q, SEED);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (20) step(2'b10, 1'b1);
        check("restart_dropped", dropped_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
